dmem_bus: RTL and testbench

DMEM_BUS -- requirements
Module: dmem_bus

---
 rtl/dmem_bus.sv | 183 ++++++++++++++++++
 tb/tb_dmem_bus.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus.sv
// dmem_bus: CPU data bus -- RAM with combinational loads and byte-lane stores at the clock edge.
// Define DMEM_BUS_MMIO_EN to add TXREG (byte FIFO, full pushes dropped with sticky overflow) and CYCREG.

// dmem_fifo: valid/ready FIFO; head visible with zero latency, push accepted when not full or popping.
module dmem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_vld  = !empty;
  assign pop_dat  = mem[rd_ptr];
  assign pop      = pop_vld && pop_rdy;
  assign push_rdy = !full || pop;
  assign push     = push_vld && push_rdy;

  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

module dmem_bus #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wena,
  input  logic [1:0]  wbh,
  input  logic        wbh_fh,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          is_half;
  logic          is_byte;
  logic          ram_hit;
  logic          store;
  logic [31:0]   ram_word;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;
  logic [3:0]    be;
  logic [31:0]   wdat;

  assign is_half  = (wbh == 2'b01);
  assign is_byte  = (wbh == 2'b10);
  assign misalign = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
  assign ram_hit  = (addr < RAM_BYTES);
  assign widx     = addr[AW+1:2];
  assign store    = wena && !misalign && !reset;

  assign ram_word  = ram[widx];
  assign lane_byte = 8'(ram_word >> {addr[1:0], 3'b000});
  assign lane_half = addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    ram_rdata = ram_word;
    if (is_byte)      ram_rdata = {{24{wbh_fh & lane_byte[7]}}, lane_byte};
    else if (is_half) ram_rdata = {{16{wbh_fh & lane_half[15]}}, lane_half};
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be   = 4'b1111;
    wdat = wdata;
    if (is_byte) begin
      be   = 4'b0001 << addr[1:0];
      wdat = {4{wdata[7:0]}};
    end else if (is_half) begin
      be   = addr[1] ? 4'b1100 : 4'b0011;
      wdat = {2{wdata[15:0]}};
    end
  end

  always_ff @(posedge clock) begin
    if (store && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

`ifdef DMEM_BUS_MMIO_EN
  localparam logic [31:0] TX_ADDR  = 32'h1000_0000;
  localparam logic [31:0] CYC_ADDR = 32'h1000_0004;

  logic [31:0] cyc;
  logic        overflow;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push_rdy;

  assign push_req = store && (addr == TX_ADDR);

  dmem_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push_req),
    .push_rdy (push_rdy),
    .push_dat (wdata[7:0]),
    .pop_vld  (tx_valid),
    .pop_rdy  (tx_ready),
    .pop_dat  (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc      <= '0;
      overflow <= 1'b0;
    end else begin
      cyc <= (store && (addr == CYC_ADDR)) ? 32'd0 : cyc + 32'd1;
      if (push_req && !push_rdy) overflow <= 1'b1;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (addr == TX_ADDR)       mmio_rdata = {29'b0, overflow, fifo_full, fifo_empty};
    else if (addr == CYC_ADDR) mmio_rdata = cyc;
  end
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign mmio_rdata      = '0;
  assign tx_data         = '0;
  assign tx_valid        = 1'b0;
`endif

  assign rdata = misalign ? 32'h0 : (ram_hit ? ram_rdata : mmio_rdata);
endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: randomized and directed stimulus; a byte-array/queue reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_dmem_bus;
  localparam int          DW  = 1024;
  localparam int          FD  = 8;
  localparam logic [31:0] TXA = 32'h1000_0000;
  localparam logic [31:0] CYA = 32'h1000_0004;
`ifdef DMEM_BUS_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wena;
  logic [1:0]  wbh;
  logic        wbh_fh;
  logic [31:0] rdata;
  logic        misalign;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clock = ~clock;

  dmem_bus #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .wena     (wena),
    .wbh      (wbh),
    .wbh_fh   (wbh_fh),
    .rdata    (rdata),
    .misalign (misalign),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        txv;
    logic [7:0]  txd;
    bit          txd_chk;
    bit          lit_en;
    logic [31:0] lit;
    int          tag;
  } exp_t;

  logic [7:0]  mem_m [DW*4];
  logic [7:0]  fifo_m [$];
  bit          ovf_m;
  logic [31:0] cyc_m;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [7:0]  got_q [$];
  bit          rdy_g;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, req);
    end
  endtask

  function automatic bit f_mis(input logic [31:0] a, input logic [1:0] w);
    case (w)
      2'b01:   return a[0];
      2'b10:   return 1'b0;
      default: return a[1:0] != 2'b00;
    endcase
  endfunction

  function automatic int f_size(input logic [1:0] w);
    return (w == 2'b01) ? 2 : ((w == 2'b10) ? 1 : 4);
  endfunction

  function automatic logic [31:0] f_read(input logic [31:0] a, input logic [1:0] w, input bit fh);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = f_size(w);
    if (f_mis(a, w)) return 32'h0;
    if (a < DW*4) begin
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[a+i]) << (8*i));
      if (fh && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
    end
    if (MMIO && a == TXA) return {29'b0, ovf_m, fifo_m.size() == FD, fifo_m.size() == 0};
    if (MMIO && a == CYA) return cyc_m;
    return 32'h0;
  endfunction

  // One bus cycle: expectation from the state before the edge, then the model steps past the edge.
  task automatic op(input logic [31:0] a, input logic [31:0] d, input bit we, input logic [1:0] w,
                    input bit fh, input bit rdy, input bit rst, input bit lit_en,
                    input logic [31:0] lit, input int tag);
    exp_t e;
    bit mis, pop, full_pre;
    @(posedge clock);
    #1;
    addr = a; wdata = d; wena = we; wbh = w; wbh_fh = fh; tx_ready = rdy; reset = rst;
    mis       = f_mis(a, w);
    e.rd      = f_read(a, w, fh);
    e.mis     = mis;
    e.txv     = (fifo_m.size() != 0);
    e.txd     = e.txv ? fifo_m[0] : 8'h00;
    e.txd_chk = e.txv || !MMIO;
    e.lit_en  = lit_en;
    e.lit     = lit;
    e.tag     = tag;
    exp_q.push_back(e);
    if (rst) begin
      fifo_m.delete();
      ovf_m = 1'b0;
      cyc_m = 32'h0;
    end else begin
      full_pre = (fifo_m.size() == FD);
      pop      = e.txv && rdy;
      if (pop) void'(fifo_m.pop_front());
      if (we && !mis && MMIO && a == TXA) begin
        if (!full_pre || pop) fifo_m.push_back(d[7:0]);
        else ovf_m = 1'b1;
      end
      if (we && !mis && a < DW*4)
        for (int i = 0; i < f_size(w); i++) mem_m[a+i] = d[8*i +: 8];
      cyc_m = (we && !mis && MMIO && a == CYA) ? 32'h0 : cyc_m + 32'd1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    op(a, d, 1'b1, w, 1'b0, rdy_g, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] w, input bit fh, input bit lit_en,
                    input logic [31:0] lit, input int tag);
    op(a, 32'h0, 1'b0, w, fh, rdy_g, 1'b0, lit_en, lit, tag);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("rdata", mon_e.tag, rdata, mon_e.rd);
      chk("misalign", mon_e.tag, 32'(misalign), 32'(mon_e.mis));
      chk("tx_valid", mon_e.tag, 32'(tx_valid), 32'(mon_e.txv));
      if (mon_e.txd_chk) chk("tx_data", mon_e.tag, 32'(tx_data), 32'(mon_e.txd));
      if (mon_e.lit_en) chk("rdata_lit", mon_e.tag, rdata, mon_e.lit);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) got_q.push_back(tx_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    int          k;
    addr = 0; wdata = 0; wena = 0; wbh = 0; wbh_fh = 0; tx_ready = 0; reset = 1; rdy_g = 0;
    repeat (3) @(posedge clock);
    fifo_m.delete();
    ovf_m = 1'b0;
    cyc_m = 32'h0;

    rd(TXA, 2'b00, 1'b0, 1'b1, MMIO ? 32'h1 : 32'h0, 1);
    rd(CYA, 2'b00, 1'b0, 1'b0, 32'h0, 1);

    wr(32'h10, 32'h1122_3344, 2'b00);
    rd(32'h13, 2'b10, 1'b1, 1'b1, 32'h0000_0011, 34);
    rd(32'h12, 2'b01, 1'b1, 1'b1, 32'h0000_1122, 34);

    wr(32'h20, 32'hAAAA_AAAA, 2'b00);
    wr(32'h21, 32'h0000_0080, 2'b10);
    rd(32'h21, 2'b10, 1'b1, 1'b1, 32'hFFFF_FF80, 35);
    rd(32'h21, 2'b10, 1'b0, 1'b1, 32'h0000_0080, 35);
    rd(32'h20, 2'b00, 1'b0, 1'b1, 32'hAAAA_80AA, 35);

    op(32'h12, 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 36);
    rd(32'h10, 2'b00, 1'b0, 1'b1, 32'h1122_3344, 36);
    rd(32'h11, 2'b01, 1'b0, 1'b1, 32'h0, 36);

    wr(32'h30, 32'hCAFE_F00D, 2'b11);
    rd(32'h30, 2'b11, 1'b1, 1'b1, 32'hCAFE_F00D, 40);
    wr(32'h32, 32'h1234_BEEF, 2'b01);
    rd(32'h30, 2'b00, 1'b0, 1'b1, 32'hBEEF_F00D, 40);
    rd(32'h32, 2'b01, 1'b1, 1'b1, 32'hFFFF_BEEF, 40);
    wr(32'(DW*4), 32'h1, 2'b00);
    rd(32'(DW*4), 2'b00, 1'b0, 1'b1, 32'h0, 41);
    rd(32'h1000_0008, 2'b00, 1'b0, 1'b1, 32'h0, 41);
    wr(32'(DW*4-4), 32'h0102_0304, 2'b00);
    rd(32'(DW*4-1), 2'b10, 1'b0, 1'b1, 32'h0000_0001, 41);

`ifdef DMEM_BUS_MMIO_EN
    rdy_g = 1'b0;
    for (int i = 1; i <= 9; i++) wr(TXA, 32'hFFFF_FF00 | 32'(i), 2'(i % 3));
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h6, 37);
    got_q.delete();
    rdy_g = 1'b1;
    repeat (10) rd(TXA, 2'b00, 1'b0, 1'b0, 32'h0, 37);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h5, 37);
    @(negedge clock); #1;
    chk("tx_count_37", 37, 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("tx_order_37", 37, 32'(got_q[i]), 32'(i + 1));

    op(32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 38);
    op(32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 38);
    rdy_g = 1'b0;
    for (int i = 0; i < 8; i++) wr(TXA, 32'hA0 + 32'(i), 2'b10);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h2, 38);
    got_q.delete();
    op(TXA, 32'h55, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 38);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h2, 38);
    rdy_g = 1'b1;
    repeat (10) rd(TXA, 2'b00, 1'b0, 1'b0, 32'h0, 38);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h1, 38);
    @(negedge clock); #1;
    chk("tx_count_38", 38, 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("tx_order_38", 38, 32'(got_q[i]), 32'hA0 + 32'(i));
    if (got_q.size() > 8) chk("tx_last_38", 38, 32'(got_q[8]), 32'h55);

    wr(CYA, 32'hFFFF, 2'b00);
    rd(CYA, 2'b00, 1'b0, 1'b1, 32'h0, 39);
    rd(CYA, 2'b00, 1'b0, 1'b1, 32'h1, 39);
    rdy_g = 1'b0;
    for (int i = 0; i < 3; i++) wr(TXA, 32'h70 + 32'(i), 2'b00);
    wr(32'h40, 32'h5A5A_1234, 2'b00);
    op(32'h40, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5A5A_1234, 39);
    op(32'h44, 32'h0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 39);
    rd(CYA, 2'b00, 1'b0, 1'b1, 32'h0, 39);
    rd(32'h40, 2'b00, 1'b0, 1'b1, 32'h5A5A_1234, 39);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h1, 39);
`else
    wr(TXA, 32'h41, 2'b00);
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h0, 33);
    wr(CYA, 32'h5, 2'b00);
    rd(CYA, 2'b00, 1'b0, 1'b1, 32'h0, 33);
    rdy_g = 1'b1;
    rd(TXA, 2'b00, 1'b0, 1'b1, 32'h0, 33);
    wr(32'h40, 32'h5A5A_1234, 2'b00);
    op(32'h40, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5A5A_1234, 39);
    rd(32'h40, 2'b00, 1'b0, 1'b1, 32'h5A5A_1234, 39);
`endif

    for (int i = 0; i < 64; i++) wr(32'(i * 4), $urandom, 2'b00);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      w = 2'($urandom_range(0, 3));
      case (k)
        0:       a = TXA + 32'($urandom_range(0, 1));
        1:       a = CYA;
        2:       a = 32'(DW*4) + 32'($urandom_range(0, 255));
        3:       a = 32'h1000_0008 + 32'($urandom_range(0, 7));
        4:       a = 32'(DW*4-4) + 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'b01)      a[0]   = 1'b0;
        else if (w != 2'b10) a[1:0] = 2'b00;
      end
      op(a, $urandom, $urandom_range(0, 2) == 0, w, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, 1'b0, 32'h0, 100);
    end

    @(negedge clock); #1;
    chk("scoreboard_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
